riscv_v_hazard_ctrl: RTL and testbench
======================================

// Module: riscv_v_hazard_ctrl
// PURPOSE
//  Issue controller for the vector pipeline: tracks in-flight vector register writes (EXE..WB) and
//  multi-cycle multiplies, and generates riscv_v_stall for the ID stage on RAW hazards or busy EXE.
//  Sits beside riscv_v_decode; the stall output feeds the decode/EXE stage enables.
//  Inserts a bubble into EXE while ID is held.
// PARAMETERS
//  NUM_VREGS  32  number of architectural vector registers
//  ADDR_W     5   vector register address width, $clog2(NUM_VREGS)
//  PIPE_DEPTH 3   tracked stages after ID: 0=EXE, 1=MEM, PIPE_DEPTH-1=WB; range 2..8
//  MUL_LAT    3   cycles a multiply occupies EXE; 1 = single cycle; range 1..15
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous reset, active-low
//  clear_pipe     in   1          synchronous flush of all in-flight state
//  riscv_stall    in   1          global freeze from integer core
//  valid_id       in   1          vector instruction present in ID
//  vd_wr_en_id    in   1          instruction writes vd
//  vd_id          in   ADDR_W     destination register
//  vs1_rd_en_id   in   1          reads vs1
//  vs1_id         in   ADDR_W     source register 1
//  vs2_rd_en_id   in   1          reads vs2
//  vs2_id         in   ADDR_W     source register 2
//  vm_rd_en_id    in   1          reads mask register v0
//  is_mul_id      in   1          instruction is a multiply
//  riscv_v_stall  out  1          hold ID, bubble into EXE
//  exe_hold       out  1          EXE occupied by multiply, EXE result not advancing
//  pending_mask   out  NUM_VREGS  bit r set = valid tracked write to register r
// BEHAVIOUR
//  - Reset: all tag valids 0, cnt 0, state IDLE. Outputs riscv_v_stall=0, exe_hold=0, pending_mask=0.
//  - Tag pipe: PIPE_DEPTH entries {valid, addr}.
//    - Entry 0 is loaded at accept, where accept = valid_id & ~riscv_v_stall & ~riscv_stall.
//    - Entry 0 stores valid=vd_wr_en_id, addr=vd_id.
//    - Entry 0 takes a bubble (valid=0) when not accepted and EXE is advancing.
//  - Advance: when ~riscv_stall & ~exe_hold, entry i moves to i+1 and the last entry retires.
//    - When exe_hold=1: entry 0 holds; entries 1.. still advance, with a bubble into entry 1.
//    - When riscv_stall=1: every entry, cnt and state freeze.
//  - hazard = any enabled source (vs1, vs2, v0 when vm_rd_en_id) equal to the addr of a valid entry,
//    WB entry included. The register file write becomes visible the cycle after WB; there is no bypass.
//  - riscv_v_stall = valid_id & (hazard | exe_hold). Combinational; independent of riscv_stall.
//  - pending_mask: combinational OR of decoded valid entries.
//  - FSM IDLE/MUL_BUSY; exe_hold = (state==MUL_BUSY).
//    - IDLE -> MUL_BUSY: accept & is_mul_id & MUL_LAT>1. Load cnt=MUL_LAT-1.
//    - MUL_BUSY: cnt decrements each unfrozen cycle; at cnt==1 the next state is IDLE.
//    - Net effect: the multiply leaves EXE exactly MUL_LAT cycles after accept, absent riscv_stall.
//  - clear_pipe (synchronous, priority over advance/accept and over riscv_stall):
//    all valids 0, cnt 0, state IDLE next cycle.
//  - Reset mid-multiply or with full pipe: immediate return to reset values, no residual stall.
//  - Simultaneous retire and read of the same register: the WB entry still counts, so stall 1 cycle.
//  - Same vd in several entries: each is tracked independently; the hazard clears only after the last retires.
//  - Self-dependence (vd==vs1 within one instruction) is not a hazard.
// TESTING
//  1. Reset low mid-traffic then released -> all outputs 0; first valid_id with no prior writes is
//     accepted, stall=0.
//  2. Write v5, next cycle read vs1=v5 (PIPE_DEPTH=3) -> stall for exactly 3 cycles, accepted on
//     4th; pending_mask[5] high for 3 cycles.
//  3. Multiply (MUL_LAT=3) writing v2, then independent add v7<=v8,v9 -> add stalled 2 cycles by
//     exe_hold; mul tag reaches MEM 3 cycles after accept.
//  4. Write v1 then riscv_stall=1 for 4 cycles with a v1 reader in ID -> pipe frozen, stall stays 1;
//     resolves 3 cycles after riscv_stall drops.
//  5. vm_rd_en_id=1 reader after write to v0 -> stall; same reader with vm_rd_en_id=0 -> no stall.
//  6. clear_pipe during MUL_BUSY with 3 valid tags -> next cycle pending_mask=0, exe_hold=0,
//     dependent reader accepted.

Source files
------------

// File: rtl/riscv_v_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_v_hazard_ctrl
//
// Issue controller for the vector pipeline. It tracks vector register writes
// that are in flight between EXE and WB, and it tracks multi-cycle multiplies
// that occupy EXE. From these it produces the ID-stage stall:
//   - a read-after-write hazard on vs1, vs2 or the v0 mask stalls ID, or
//   - a multiply that is still in EXE stalls ID.
// While ID is held, a bubble is inserted into EXE.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active low
//   clear_pipe     synchronous flush of all in-flight state; wins over everything
//   riscv_stall    global freeze from the integer core
//   valid_id       a vector instruction is present in ID
//   vd_wr_en_id    the ID instruction writes vd_id
//   vd_id          destination register of the ID instruction
//   vs1_rd_en_id   the ID instruction reads vs1_id
//   vs1_id         source register 1
//   vs2_rd_en_id   the ID instruction reads vs2_id
//   vs2_id         source register 2
//   vm_rd_en_id    the ID instruction reads the mask register v0
//   is_mul_id      the ID instruction is a multiply
//   riscv_v_stall  hold ID and bubble EXE (combinational)
//   exe_hold       EXE is occupied by a multiply and does not advance
//   pending_mask   bit r set while a tracked write to register r is in flight
// -----------------------------------------------------------------------------
module riscv_v_hazard_ctrl #(
   parameter int NUM_VREGS  = 32,
   parameter int ADDR_W     = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int MUL_LAT    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_pipe,
   input  logic                 riscv_stall,
   input  logic                 valid_id,
   input  logic                 vd_wr_en_id,
   input  logic [ADDR_W-1:0]    vd_id,
   input  logic                 vs1_rd_en_id,
   input  logic [ADDR_W-1:0]    vs1_id,
   input  logic                 vs2_rd_en_id,
   input  logic [ADDR_W-1:0]    vs2_id,
   input  logic                 vm_rd_en_id,
   input  logic                 is_mul_id,
   output logic                 riscv_v_stall,
   output logic                 exe_hold,
   output logic [NUM_VREGS-1:0] pending_mask
);

   // MUL_LAT is at most 15, so the remaining-cycle counter never exceeds 14.
   localparam int CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   state_t                              state_reg, state_next;
   logic [CNT_W-1:0]                    cnt_reg, cnt_next;

   // Tag pipe: index 0 = EXE, 1 = MEM, PIPE_DEPTH-1 = WB.
   logic [PIPE_DEPTH-1:0]               tag_valid_reg, tag_valid_next;
   logic [PIPE_DEPTH-1:0][ADDR_W-1:0]   tag_addr_reg, tag_addr_next;

   logic [PIPE_DEPTH-1:0]               src_hit;
   logic                                hazard;
   logic                                accept;
   logic                                mul_start;

   // ------------------------------------------------------------------------
   // Hazard detection: every valid entry, WB included, blocks a reader because
   // the register file write only becomes visible the cycle after WB and there
   // is no bypass. The instruction in ID is not in the tag pipe, so vd==vs1
   // within one instruction is never seen as a hazard.
   // ------------------------------------------------------------------------
   genvar gi, gj;
   generate
      for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_hit
         assign src_hit[gi] = tag_valid_reg[gi] &
                              ((vs1_rd_en_id & (tag_addr_reg[gi] == vs1_id)) |
                               (vs2_rd_en_id & (tag_addr_reg[gi] == vs2_id)) |
                               (vm_rd_en_id  & (tag_addr_reg[gi] == '0)));
      end
   endgenerate

   assign hazard        = |src_hit;
   assign exe_hold      = (state_reg == MUL_BUSY);
   assign riscv_v_stall = valid_id & (hazard | exe_hold);
   assign accept        = valid_id & ~riscv_v_stall & ~riscv_stall;
   assign mul_start     = accept & is_mul_id & (MUL_LAT > 1);

   // ------------------------------------------------------------------------
   // Pending mask: one decoder per architectural register, OR-ed over entries.
   // ------------------------------------------------------------------------
   generate
      for (gi = 0; gi < NUM_VREGS; gi++) begin : g_mask
         logic [PIPE_DEPTH-1:0] match;
         for (gj = 0; gj < PIPE_DEPTH; gj++) begin : g_entry
            assign match[gj] = tag_valid_reg[gj] &
                               (tag_addr_reg[gj] == ADDR_W'(gi));
         end
         assign pending_mask[gi] = |match;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Tag pipe next state.
   //   clear_pipe  : drop everything, even under a global freeze
   //   riscv_stall : hold everything
   //   exe_hold    : EXE keeps the multiply; MEM..WB drain, bubble into MEM
   //   otherwise   : shift, EXE loads the accepted write or a bubble
   // ------------------------------------------------------------------------
   always_comb begin
      tag_valid_next = tag_valid_reg;
      tag_addr_next  = tag_addr_reg;
      if (clear_pipe) begin
         tag_valid_next = '0;
      end else if (!riscv_stall) begin
         for (int i = PIPE_DEPTH - 1; i >= 1; i--) begin
            tag_valid_next[i] = tag_valid_reg[i-1];
            tag_addr_next[i]  = tag_addr_reg[i-1];
         end
         if (exe_hold) begin
            // The multiply stays in EXE, so it must not also appear in MEM.
            tag_valid_next[0] = tag_valid_reg[0];
            tag_addr_next[0]  = tag_addr_reg[0];
            tag_valid_next[1] = 1'b0;
         end else begin
            tag_valid_next[0] = accept & vd_wr_en_id;
            tag_addr_next[0]  = vd_id;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Multiply occupancy FSM. cnt holds the number of further EXE cycles the
   // multiply needs; leaving at cnt==1 makes the multiply spend exactly
   // MUL_LAT cycles in EXE counted from the accept edge.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (clear_pipe) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else if (!riscv_stall) begin
         case (state_reg)
            IDLE: begin
               if (mul_start) begin
                  state_next = MUL_BUSY;
                  cnt_next   = CNT_W'(MUL_LAT - 1);
               end
            end
            MUL_BUSY: begin
               cnt_next = cnt_reg - 1'b1;
               if (cnt_reg == CNT_W'(1)) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         tag_valid_reg <= '0;
         tag_addr_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         tag_valid_reg <= tag_valid_next;
         tag_addr_reg  <= tag_addr_next;
      end
   end

endmodule

// File: tb/tb_riscv_v_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for riscv_v_hazard_ctrl. Directed scenarios plus a randomized run
// checked against a list-of-in-flight-writes reference model.
// -----------------------------------------------------------------------------
module tb_riscv_v_hazard_ctrl;

   localparam int NUM_VREGS  = 32;
   localparam int ADDR_W     = 5;
   localparam int PIPE_DEPTH = 3;
   localparam int MUL_LAT    = 3;

   logic                 clk;
   logic                 rst;
   logic                 clear_pipe;
   logic                 riscv_stall;
   logic                 valid_id;
   logic                 vd_wr_en_id;
   logic [ADDR_W-1:0]    vd_id;
   logic                 vs1_rd_en_id;
   logic [ADDR_W-1:0]    vs1_id;
   logic                 vs2_rd_en_id;
   logic [ADDR_W-1:0]    vs2_id;
   logic                 vm_rd_en_id;
   logic                 is_mul_id;
   logic                 riscv_v_stall;
   logic                 exe_hold;
   logic [NUM_VREGS-1:0] pending_mask;

   int total = 0;
   int bad   = 0;

   riscv_v_hazard_ctrl #(
      .NUM_VREGS (NUM_VREGS),
      .ADDR_W    (ADDR_W),
      .PIPE_DEPTH(PIPE_DEPTH),
      .MUL_LAT   (MUL_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clear_pipe   (clear_pipe),
      .riscv_stall  (riscv_stall),
      .valid_id     (valid_id),
      .vd_wr_en_id  (vd_wr_en_id),
      .vd_id        (vd_id),
      .vs1_rd_en_id (vs1_rd_en_id),
      .vs1_id       (vs1_id),
      .vs2_rd_en_id (vs2_rd_en_id),
      .vs2_id       (vs2_id),
      .vm_rd_en_id  (vm_rd_en_id),
      .is_mul_id    (is_mul_id),
      .riscv_v_stall(riscv_v_stall),
      .exe_hold     (exe_hold),
      .pending_mask (pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Each in-flight write is a record {register, stage}; stage 0 = EXE.
   // mul_left = number of upcoming cycles during which EXE is still held.
   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                stage;
   } wr_t;

   wr_t                  inflight[$];
   int                   mul_left;
   logic                 m_stall;
   logic                 m_hold;
   logic [NUM_VREGS-1:0] m_mask;

   task automatic model_reset();
      inflight.delete();
      mul_left = 0;
   endtask

   task automatic model_eval();
      logic hz;
      hz     = 1'b0;
      m_mask = '0;
      foreach (inflight[i]) begin
         m_mask[inflight[i].addr] = 1'b1;
         if ((vs1_rd_en_id && inflight[i].addr == vs1_id) ||
             (vs2_rd_en_id && inflight[i].addr == vs2_id) ||
             (vm_rd_en_id  && inflight[i].addr == 0))
            hz = 1'b1;
      end
      m_hold  = (mul_left > 0);
      m_stall = valid_id && (hz || m_hold);
   endtask

   task automatic model_step();
      wr_t  nq[$];
      wr_t  w;
      logic acc;
      model_eval();
      acc = valid_id && !m_stall && !riscv_stall;
      if (!rst) begin
         model_reset();
      end else if (clear_pipe) begin
         model_reset();
      end else if (!riscv_stall) begin
         foreach (inflight[i]) begin
            w = inflight[i];
            if (!(m_hold && w.stage == 0)) w.stage = w.stage + 1;
            if (w.stage < PIPE_DEPTH) nq.push_back(w);
         end
         if (!m_hold && acc && vd_wr_en_id) begin
            w.addr  = vd_id;
            w.stage = 0;
            nq.push_back(w);
         end
         if (m_hold) mul_left = mul_left - 1;
         else if (acc && is_mul_id && MUL_LAT > 1) mul_left = MUL_LAT - 1;
         inflight = nq;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic v, input logic wr, input logic [ADDR_W-1:0] vd,
                        input logic r1, input logic [ADDR_W-1:0] s1,
                        input logic r2, input logic [ADDR_W-1:0] s2,
                        input logic vm, input logic mul);
      valid_id     = v;
      vd_wr_en_id  = wr;
      vd_id        = vd;
      vs1_rd_en_id = r1;
      vs1_id       = s1;
      vs2_rd_en_id = r2;
      vs2_id       = s2;
      vm_rd_en_id  = vm;
      is_mul_id    = mul;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance one clock edge; inputs are stable until the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      clear_pipe  = 1'b0;
      riscv_stall = 1'b0;
      for (int i = 0; i < PIPE_DEPTH + MUL_LAT + 2; i++) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      clear_pipe = 1'b0;
      riscv_stall = 1'b0;
      idle();
      model_reset();
      #1;
      total++;
      if ({riscv_v_stall, exe_hold, pending_mask} !== '0) begin
         bad++;
         $display("FAIL reset_por stall=%b hold=%b mask=%h required all 0", riscv_v_stall, exe_hold, pending_mask);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      // Traffic: multiply writing v9, then a stalled write to v10.
      drive(1, 1, 9, 0, 0, 0, 0, 0, 1);
      tick();
      drive(1, 1, 10, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      total++;
      if (exe_hold !== 1'b1 || pending_mask[9] !== 1'b1) begin
         bad++;
         $display("FAIL reset_traffic hold=%b mask9=%b required 1 1", exe_hold, pending_mask[9]);
      end
      @(posedge clk); #1;       // edge not modelled: redo model for this edge
      model_reset();
      // Re-synchronise model: the edge above advanced the DUT; reset now wipes both.
      rst = 1'b0;
      #1;
      total++;
      if ({riscv_v_stall, exe_hold, pending_mask} !== '0) begin
         bad++;
         $display("FAIL reset_mid stall=%b hold=%b mask=%h required all 0", riscv_v_stall, exe_hold, pending_mask);
      end
      tick();
      rst = 1'b1;
      drive(1, 0, 0, 1, 9, 1, 10, 0, 0);
      @(negedge clk);
      total++;
      if (riscv_v_stall !== 1'b0 || pending_mask !== '0) begin
         bad++;
         $display("FAIL reset_first_accept stall=%b mask=%h required 0 0", riscv_v_stall, pending_mask);
      end
      tick();
      drain();
   endtask

   task automatic test_raw();
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 10, 1, 5, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (riscv_v_stall !== (k < 3)) begin
            bad++;
            $display("FAIL raw_stall k=%0d got=%b required=%b", k, riscv_v_stall, (k < 3));
         end
         total++;
         if (pending_mask[5] !== (k < 3)) begin
            bad++;
            $display("FAIL raw_mask5 k=%0d got=%b required=%b", k, pending_mask[5], (k < 3));
         end
         tick();
      end
      idle();
      @(negedge clk);
      total++;
      if (pending_mask !== 32'h0000_0400) begin
         bad++;
         $display("FAIL raw_reader_write mask=%h required=00000400", pending_mask);
      end
      drain();
   endtask

   task automatic test_mul();
      drive(1, 1, 2, 0, 0, 0, 0, 0, 1);
      tick();
      drive(1, 1, 7, 1, 8, 1, 9, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (riscv_v_stall !== (k < 2) || exe_hold !== (k < 2)) begin
            bad++;
            $display("FAIL mul_hold k=%0d stall=%b hold=%b required=%b", k, riscv_v_stall, exe_hold, (k < 2));
         end
         tick();
      end
      idle();
      // Multiply reached MEM at the add's accept edge: WB next, then retire.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (pending_mask[2] !== (k < 2) || pending_mask[7] !== 1'b1) begin
            bad++;
            $display("FAIL mul_tag k=%0d mask2=%b mask7=%b required %b 1", k, pending_mask[2], pending_mask[7], (k < 2));
         end
         tick();
      end
      drain();
   endtask

   task automatic test_freeze();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
      riscv_stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (riscv_v_stall !== 1'b1 || pending_mask[1] !== 1'b1) begin
            bad++;
            $display("FAIL freeze k=%0d stall=%b mask1=%b required 1 1", k, riscv_v_stall, pending_mask[1]);
         end
         tick();
      end
      riscv_stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (riscv_v_stall !== (k < 3)) begin
            bad++;
            $display("FAIL unfreeze k=%0d stall=%b required=%b", k, riscv_v_stall, (k < 3));
         end
         tick();
      end
      drain();
   endtask

   task automatic test_vmask();
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      total++;
      if (riscv_v_stall !== 1'b1) begin
         bad++;
         $display("FAIL vm_read stall=%b required=1", riscv_v_stall);
      end
      #1;
      vm_rd_en_id = 1'b0;
      #1;
      total++;
      if (riscv_v_stall !== 1'b0) begin
         bad++;
         $display("FAIL vm_unused stall=%b required=0", riscv_v_stall);
      end
      tick();
      drain();
   endtask

   task automatic test_clear();
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 6, 0, 0, 0, 0, 0, 1);
      tick();
      idle();
      @(negedge clk);
      total++;
      if (exe_hold !== 1'b1 || pending_mask !== 32'h0000_0070) begin
         bad++;
         $display("FAIL clear_setup hold=%b mask=%h required 1 00000070", exe_hold, pending_mask);
      end
      clear_pipe = 1'b1;
      tick();
      clear_pipe = 1'b0;
      drive(1, 0, 0, 1, 6, 1, 4, 0, 0);
      @(negedge clk);
      total++;
      if (pending_mask !== '0 || exe_hold !== 1'b0 || riscv_v_stall !== 1'b0) begin
         bad++;
         $display("FAIL clear_after mask=%h hold=%b stall=%b required 0 0 0", pending_mask, exe_hold, riscv_v_stall);
      end
      tick();
      drain();
   endtask

   task automatic test_back_to_back();
      // Self-dependence on an empty pipe is not a hazard.
      drive(1, 1, 12, 1, 12, 0, 0, 0, 0);
      @(negedge clk);
      total++;
      if (riscv_v_stall !== 1'b0) begin
         bad++;
         $display("FAIL self_dep stall=%b required=0", riscv_v_stall);
      end
      tick();
      drain();
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
         tick();
      end
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (riscv_v_stall !== (k < 3)) begin
            bad++;
            $display("FAIL b2b_stall k=%0d stall=%b required=%b", k, riscv_v_stall, (k < 3));
         end
         tick();
      end
      drain();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1),
               ADDR_W'($urandom_range(0, 7)),
               $urandom_range(0, 1), ADDR_W'($urandom_range(0, 7)),
               $urandom_range(0, 1), ADDR_W'($urandom_range(0, 7)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3);
         riscv_stall = ($urandom_range(0, 9) == 0);
         clear_pipe  = ($urandom_range(0, 29) == 0);
         @(negedge clk);
         model_eval();
         total++;
         if (riscv_v_stall !== m_stall || exe_hold !== m_hold || pending_mask !== m_mask) begin
            bad++;
            $display("FAIL rand n=%0d stall=%b/%b hold=%b/%b mask=%h/%h (got/required)",
                     n, riscv_v_stall, m_stall, exe_hold, m_hold, pending_mask, m_mask);
         end
         tick();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_mul();
      test_freeze();
      test_vmask();
      test_clear();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
